// File: rtl/cr_structs_pkg.sv
// Shared AXI4-Stream datapath types and arbitration constants for the CR stream blocks.
package cr_structs;

    localparam int AXI_S_DATA_WIDTH = 32;
    localparam int AXI_S_KEEP_WIDTH = AXI_S_DATA_WIDTH / 8;
    localparam int AXI_S_TID_WIDTH  = 4;
    localparam int AXI_S_USER_WIDTH = 4;

    localparam int CR_ARB_RR = 0;
    localparam int CR_ARB_FP = 1;

    // Register slice handshake flavours: FWD = single forward register, FULL = 2-entry skid.
    localparam int AXI_RS_FWD  = 1;
    localparam int AXI_RS_FULL = 2;

    typedef struct packed {
        logic [AXI_S_DATA_WIDTH-1:0] tdata;
        logic [AXI_S_KEEP_WIDTH-1:0] tkeep;
        logic [AXI_S_TID_WIDTH-1:0]  tid;
        logic [AXI_S_USER_WIDTH-1:0] tuser;
        logic                        tlast;
    } axi4s_payload_t;

    typedef struct packed {
        logic           tvalid;
        axi4s_payload_t pl;
    } axi4s_dp_bus_t;

    typedef struct packed {
        logic tready;
    } axi4s_dp_rdy_t;

endpackage

// File: rtl/axi_channel_reg_slice.sv
// Generic valid/ready register slice; FULL mode is a 2-entry skid buffer that cuts both
// the forward path and the ready path while sustaining one transfer per clock.
module axi_channel_reg_slice
    import cr_structs::*;
#(
    parameter int PAYLD_WIDTH = 8,
    parameter int HNDSHK_MODE = AXI_RS_FULL
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PAYLD_WIDTH-1:0] in_payld,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PAYLD_WIDTH-1:0] out_payld
);

    logic                   out_valid_reg;
    logic [PAYLD_WIDTH-1:0] out_payld_reg;

    assign out_valid = out_valid_reg;
    assign out_payld = out_payld_reg;

    if (HNDSHK_MODE == AXI_RS_FULL) begin : g_full
        logic                   skid_valid_reg;
        logic [PAYLD_WIDTH-1:0] skid_payld_reg;

        // Ready depends only on the skid register, so upstream never sees out_ready combinationally.
        assign in_ready = ~skid_valid_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_valid_reg  <= 1'b0;
                out_payld_reg  <= '0;
                skid_valid_reg <= 1'b0;
                skid_payld_reg <= '0;
            end else if (out_ready || !out_valid_reg) begin
                if (skid_valid_reg) begin
                    out_valid_reg  <= 1'b1;
                    out_payld_reg  <= skid_payld_reg;
                    skid_valid_reg <= 1'b0;
                end else begin
                    out_valid_reg <= in_valid;
                    if (in_valid) begin
                        out_payld_reg <= in_payld;
                    end
                end
            end else if (in_valid && !skid_valid_reg) begin
                skid_valid_reg <= 1'b1;
                skid_payld_reg <= in_payld;
            end
        end
    end else begin : g_fwd
        assign in_ready = ~out_valid_reg | out_ready;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_valid_reg <= 1'b0;
                out_payld_reg <= '0;
            end else if (in_ready) begin
                out_valid_reg <= in_valid;
                if (in_valid) begin
                    out_payld_reg <= in_payld;
                end
            end
        end
    end

endmodule

// File: rtl/cr_axi4s_mstr_arb.sv
// N-channel AXI4-Stream master: packet-atomic arbitration over show-ahead FIFOs,
// one pop register, then a full register slice to the shared outbound port.
module cr_axi4s_mstr_arb
    import cr_structs::*;
#(
    parameter int N_CH       = 4,
    parameter int ARB_MODE   = CR_ARB_RR,
    parameter int TID_INSERT = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  axi4s_dp_bus_t [N_CH-1:0]       axi4s_in,
    input  logic          [N_CH-1:0]       axi4s_in_empty,
    output logic          [N_CH-1:0]       axi4s_mstr_rd,
    input  axi4s_dp_rdy_t                  axi4s_ob_in,
    output axi4s_dp_bus_t                  axi4s_ob_out,
    output logic          [N_CH-1:0]       arb_grant,
    output logic                           arb_busy
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_LOCK
    } arb_state_t;

    arb_state_t        state_reg;
    logic [N_CH-1:0]   grant_reg;
    logic [IDX_W-1:0]  gnt_idx_reg;
    logic [IDX_W-1:0]  rr_ptr_reg;
    logic              busy_reg;
    axi4s_dp_bus_t     s1_reg;

    logic [N_CH-1:0]   req;
    logic              s1_tready;
    logic              can_pop;
    logic              pop;
    axi4s_payload_t    pop_beat;
    axi4s_payload_t    s1_load;
    logic [IDX_W-1:0]  cand_idx [N_CH];
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_found;
    logic [N_CH-1:0]   pick_onehot;

    // Wrap is an explicit compare so non-power-of-2 channel counts rotate correctly.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_CH) begin
            sum = sum - N_CH;
        end
        return IDX_W'(sum);
    endfunction

    assign req           = ~axi4s_in_empty;
    assign can_pop       = ~s1_reg.tvalid | s1_tready;
    assign axi4s_mstr_rd = grant_reg & req & {N_CH{can_pop}};
    assign pop           = |axi4s_mstr_rd;
    assign pop_beat      = axi4s_in[gnt_idx_reg].pl;
    assign arb_grant     = grant_reg;
    assign arb_busy      = busy_reg;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_cand
        assign cand_idx[gi] = (ARB_MODE == CR_ARB_FP) ? IDX_W'(gi) : wrap_add(rr_ptr_reg, gi);
    end

    // Candidates are pre-ordered by priority, so the first requesting one wins.
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (!pick_found && req[cand_idx[k]]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx[k];
            end
        end
    end

    always_comb begin
        pick_onehot           = '0;
        pick_onehot[pick_idx] = 1'b1;
    end

    always_comb begin
        s1_load = pop_beat;
        if (TID_INSERT != 0) begin
            s1_load.tid = AXI_S_TID_WIDTH'(gnt_idx_reg);
        end
    end

    // Grant is only issued from IDLE, which guarantees one bubble between packets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            grant_reg   <= '0;
            gnt_idx_reg <= '0;
            rr_ptr_reg  <= '0;
            busy_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_reg   <= pick_onehot;
                        gnt_idx_reg <= pick_idx;
                        busy_reg    <= 1'b1;
                        state_reg   <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (pop && pop_beat.tlast) begin
                        grant_reg  <= '0;
                        busy_reg   <= 1'b0;
                        rr_ptr_reg <= (gnt_idx_reg == IDX_W'(N_CH - 1)) ? '0 : gnt_idx_reg + 1'b1;
                        state_reg  <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg <= '0;
        end else if (pop) begin
            s1_reg.tvalid <= 1'b1;
            s1_reg.pl     <= s1_load;
        end else if (s1_reg.tvalid && s1_tready) begin
            s1_reg.tvalid <= 1'b0;
        end
    end

    logic           ob_valid;
    axi4s_payload_t ob_payld;

    axi_channel_reg_slice #(
        .PAYLD_WIDTH ($bits(axi4s_payload_t)),
        .HNDSHK_MODE (AXI_RS_FULL)
    ) u_ob_slice (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_reg.tvalid),
        .in_ready  (s1_tready),
        .in_payld  (s1_reg.pl),
        .out_valid (ob_valid),
        .out_ready (axi4s_ob_in.tready),
        .out_payld (ob_payld)
    );

    assign axi4s_ob_out.tvalid = ob_valid;
    assign axi4s_ob_out.pl     = ob_payld;

endmodule
